// File: rtl/threadgroup_array.sv
// ============================================================================
// Module   : threadgroup_array
// Purpose  : NW x NA grid of signed K-element dot-product lanes. Every weight
//            group is broadcast to all activation groups. Each lane starts
//            from a partial sum and accumulates STEPS input beats before it
//            offers a result through a valid/ready handshake.
// Options  : define THREADGROUP_ARRAY_SATURATE_EN to clamp results to RW bits.
//            Leave it undefined to keep the low RW bits (two's-complement wrap).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module threadgroup_array #(
  parameter int NW    = 2,
  parameter int NA    = 2,
  parameter int K     = 4,
  parameter int DW    = 8,
  parameter int RW    = 16,
  parameter int STEPS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NW*K*DW-1:0]    weight_bus,
  input  logic [NA*K*DW-1:0]    act_bus,
  input  logic [NW*NA*RW-1:0]   psum_bus,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NW*NA*RW-1:0]   result_bus,
  output logic                  busy
);

  // The accumulator is wide enough that STEPS beats of K full-scale products
  // plus a partial sum can never wrap. It is never narrower than the result.
  localparam int ACCW_RAW = 2*DW + $clog2(K) + $clog2(STEPS) + 1;
  localparam int ACCW     = (ACCW_RAW > RW) ? ACCW_RAW : RW;
  localparam int CW       = $clog2(STEPS + 1);
  localparam logic [CW-1:0] c_LAST = CW'(STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic          w_accept;

  assign w_accept = in_valid && in_ready;

  // State register and beat counter; the first beat restarts the count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_cnt <= (r_state == S_IDLE) ? CW'(1) : r_cnt + CW'(1);
      end
    end
  end

  // Next-state and handshake outputs; in_ready is held low while in reset.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b1;
    case (r_state)
      S_IDLE: begin
        in_ready = rst;
        busy     = 1'b0;
        if (w_accept) w_state_next = (STEPS == 1) ? S_DONE : S_ACCUM;
      end
      S_ACCUM: begin
        in_ready = rst;
        if (w_accept && (r_cnt == c_LAST)) w_state_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

`ifdef THREADGROUP_ARRAY_SATURATE_EN
  localparam logic signed [ACCW-1:0] c_SAT_MAX = ACCW'({1'b0, {(RW-1){1'b1}}});
  localparam logic signed [ACCW-1:0] c_SAT_MIN = ~c_SAT_MAX;
`endif

  for (genvar gi = 0; gi < NW; gi++) begin : g_w
    for (genvar gj = 0; gj < NA; gj++) begin : g_a
      localparam int L = gi*NA + gj;

      logic signed [DW-1:0]   w_wk;
      logic signed [DW-1:0]   w_ak;
      logic signed [2*DW-1:0] w_prod;
      logic signed [ACCW-1:0] w_dot;
      logic signed [RW-1:0]   w_psum;
      logic signed [ACCW-1:0] r_acc;
      logic        [RW-1:0]   w_res;

      assign w_psum = $signed(psum_bus[L*RW +: RW]);

      // Signed dot product of weight group gi with activation group gj.
      always_comb begin
        w_wk   = '0;
        w_ak   = '0;
        w_prod = '0;
        w_dot  = '0;
        for (int k = 0; k < K; k++) begin
          w_wk   = $signed(weight_bus[(gi*K + k)*DW +: DW]);
          w_ak   = $signed(act_bus[(gj*K + k)*DW +: DW]);
          w_prod = (2*DW)'(w_wk) * (2*DW)'(w_ak);
          w_dot  = w_dot + ACCW'(w_prod);
        end
      end

      // Lane accumulator: the first beat seeds from the partial sum.
      always_ff @(posedge clk) begin
        if (!rst) begin
          r_acc <= '0;
        end else if (w_accept) begin
          r_acc <= (r_state == S_IDLE) ? ACCW'(w_psum) + w_dot : r_acc + w_dot;
        end
      end

`ifdef THREADGROUP_ARRAY_SATURATE_EN
      // Clamp the wide accumulator into the signed RW-bit range.
      always_comb begin
        if (r_acc > c_SAT_MAX) begin
          w_res = c_SAT_MAX[RW-1:0];
        end else if (r_acc < c_SAT_MIN) begin
          w_res = c_SAT_MIN[RW-1:0];
        end else begin
          w_res = r_acc[RW-1:0];
        end
      end
`else
      assign w_res = r_acc[RW-1:0];
`endif

      assign result_bus[L*RW +: RW] = w_res;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_threadgroup_array.sv
// ============================================================================
// Module   : tb_threadgroup_array
// Purpose  : Self-checking bench for threadgroup_array using directed cases and
//            randomized transactions against an integer reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_threadgroup_array;
  localparam int NW = 2, NA = 2, K = 4, DW = 8, RW = 16, STEPS = 4;
  localparam int NL = NW*NA;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [NW*K*DW-1:0]  weight_bus = '0;
  logic [NA*K*DW-1:0]  act_bus = '0;
  logic [NL*RW-1:0]    psum_bus = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [NL*RW-1:0]    result_bus;
  logic                busy;

  int     tests_run = 0;
  int     tests_failed = 0;
  int     wv [NW][K];
  int     av [NA][K];
  int     pv [NL];
  longint exp_acc [NL];

  threadgroup_array #(.NW(NW), .NA(NA), .K(K), .DW(DW), .RW(RW), .STEPS(STEPS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .weight_bus(weight_bus), .act_bus(act_bus), .psum_bus(psum_bus),
    .out_valid(out_valid), .out_ready(out_ready), .result_bus(result_bus), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bus();
    for (int i = 0; i < NW; i++)
      for (int k = 0; k < K; k++) weight_bus[(i*K+k)*DW +: DW] = DW'(wv[i][k]);
    for (int j = 0; j < NA; j++)
      for (int k = 0; k < K; k++) act_bus[(j*K+k)*DW +: DW] = DW'(av[j][k]);
    for (int l = 0; l < NL; l++) psum_bus[l*RW +: RW] = RW'(pv[l]);
  endtask

  task automatic set_uniform(input int w, input int a, input int p);
    for (int i = 0; i < NW; i++) for (int k = 0; k < K; k++) wv[i][k] = w;
    for (int j = 0; j < NA; j++) for (int k = 0; k < K; k++) av[j][k] = a;
    for (int l = 0; l < NL; l++) pv[l] = p;
  endtask

  function automatic longint dot(input int i, input int j);
    longint s = 0;
    for (int k = 0; k < K; k++) s += longint'(wv[i][k]) * longint'(av[j][k]);
    return s;
  endfunction

  function automatic logic [RW-1:0] narrow(input longint v);
`ifdef THREADGROUP_ARRAY_SATURATE_EN
    longint hi = (longint'(1) <<< (RW-1)) - 1;
    longint lo = -hi - 1;
    if (v > hi) v = hi;
    if (v < lo) v = lo;
`endif
    return v[RW-1:0];
  endfunction

  // Presents one beat for one cycle and updates the model if it was taken.
  task automatic send_beat(input bit first, output bit taken);
    drive_bus();
    in_valid = 1'b1;
    #1;
    taken = in_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (taken)
      for (int l = 0; l < NL; l++)
        exp_acc[l] = (first ? longint'(pv[l]) : exp_acc[l]) + dot(l / NA, l % NA);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    tests_run++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || result_bus !== '0) begin
      tests_failed++;
      $display("FAIL reset: in_ready=%b out_valid=%b busy=%b result=%h, required 0 0 0 0",
               in_ready, out_valid, busy, result_bus);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release: in_ready=%b required 1", in_ready);
    end
    tick();
  endtask

  task automatic test_ones();
    bit ok;
    set_uniform(1, 2, 10);
    for (int s = 0; s < STEPS; s++) begin
      send_beat(s == 0, ok);
      tests_run++;
      if (ok !== 1'b1 || out_valid !== (s == STEPS-1)) begin
        tests_failed++;
        $display("FAIL ones_beat%0d: accepted=%b out_valid=%b required 1 %b", s, ok, out_valid, s == STEPS-1);
      end
    end
    for (int l = 0; l < NL; l++) begin
      tests_run++;
      if ($signed(result_bus[l*RW +: RW]) !== 16'sd42) begin
        tests_failed++;
        $display("FAIL ones_lane%0d: got %0d required 42", l, $signed(result_bus[l*RW +: RW]));
      end
    end
    tests_run++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL ones_done: in_ready=%b busy=%b required 0 1", in_ready, busy);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL ones_handoff: out_valid=%b busy=%b required 0 0", out_valid, busy);
    end
  endtask

  task automatic test_broadcast();
    bit ok;
    int expv [NL];
    expv = '{16, -16, 48, -48};
    set_uniform(1, 1, 0);
    for (int k = 0; k < K; k++) begin
      wv[1][k] = 3;
      av[1][k] = -1;
    end
    for (int s = 0; s < STEPS; s++) send_beat(s == 0, ok);
    for (int l = 0; l < NL; l++) begin
      tests_run++;
      if (out_valid !== 1'b1 || $signed(result_bus[l*RW +: RW]) !== 16'(expv[l])) begin
        tests_failed++;
        $display("FAIL broadcast_lane%0d: got %0d valid=%b required %0d valid=1",
                 l, $signed(result_bus[l*RW +: RW]), out_valid, expv[l]);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_saturation();
    bit ok;
    int exp_hi, exp_lo;
`ifdef THREADGROUP_ARRAY_SATURATE_EN
    exp_hi = 32767;
    exp_lo = -32768;
`else
    exp_hi = 28687;
    exp_lo = 2048;
`endif
    for (int c = 0; c < 2; c++) begin
      if (c == 0) set_uniform(127, 127, 32767);
      else        set_uniform(-128, 127, 0);
      for (int s = 0; s < STEPS; s++) send_beat(s == 0, ok);
      for (int l = 0; l < NL; l++) begin
        tests_run++;
        if ($signed(result_bus[l*RW +: RW]) !== 16'(c == 0 ? exp_hi : exp_lo)) begin
          tests_failed++;
          $display("FAIL narrow%0d_lane%0d: got %0d required %0d",
                   c, l, $signed(result_bus[l*RW +: RW]), c == 0 ? exp_hi : exp_lo);
        end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_gaps_backpressure();
    bit ok;
    set_uniform(1, 2, 10);
    for (int s = 0; s < STEPS; s++) begin
      send_beat(s == 0, ok);
      if (s < STEPS-1)
        for (int g = 0; g < 3; g++) begin
          tick();
          tests_run++;
          if (out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL gap_b%0d_c%0d: out_valid=%b busy=%b in_ready=%b required 0 1 1",
                     s, g, out_valid, busy, in_ready);
          end
        end
    end
    // Offer a different beat while stalled in DONE; it must be ignored.
    set_uniform(5, 7, 99);
    drive_bus();
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      for (int l = 0; l < NL; l++) begin
        tests_run++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || $signed(result_bus[l*RW +: RW]) !== 16'sd42) begin
          tests_failed++;
          $display("FAIL stall_c%0d_lane%0d: valid=%b in_ready=%b result=%0d required 1 0 42",
                   c, l, out_valid, in_ready, $signed(result_bus[l*RW +: RW]));
        end
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_handoff: out_valid=%b busy=%b required 0 0", out_valid, busy);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_single: out_valid=%b busy=%b required 0 0", out_valid, busy);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    set_uniform(9, -3, 1234);
    send_beat(1'b1, ok);
    send_beat(1'b0, ok);
    rst = 1'b0;
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_ready: in_ready=%b required 0", in_ready);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || result_bus !== '0) begin
      tests_failed++;
      $display("FAIL midreset_clear: out_valid=%b busy=%b result=%h required 0 0 0",
               out_valid, busy, result_bus);
    end
    rst = 1'b1;
    set_uniform(1, 2, 10);
    for (int s = 0; s < STEPS; s++) send_beat(s == 0, ok);
    for (int l = 0; l < NL; l++) begin
      tests_run++;
      if (out_valid !== 1'b1 || $signed(result_bus[l*RW +: RW]) !== 16'sd42) begin
        tests_failed++;
        $display("FAIL midreset_lane%0d: got %0d valid=%b required 42 valid=1",
                 l, $signed(result_bus[l*RW +: RW]), out_valid);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    bit ok;
    int d;
    for (int t = 0; t < 20; t++) begin
      for (int s = 0; s < STEPS; s++) begin
        for (int i = 0; i < NW; i++) for (int k = 0; k < K; k++) wv[i][k] = int'($urandom_range(0, 255)) - 128;
        for (int j = 0; j < NA; j++) for (int k = 0; k < K; k++) av[j][k] = int'($urandom_range(0, 255)) - 128;
        for (int l = 0; l < NL; l++) pv[l] = int'($urandom_range(0, 65535)) - 32768;
        send_beat(s == 0, ok);
        tests_run++;
        if (ok !== 1'b1 || out_valid !== (s == STEPS-1)) begin
          tests_failed++;
          $display("FAIL rand%0d_beat%0d: accepted=%b out_valid=%b required 1 %b",
                   t, s, ok, out_valid, s == STEPS-1);
        end
        if (s < STEPS-1) begin
          d = int'($urandom_range(0, 2));
          for (int g = 0; g < d; g++) tick();
        end
      end
      d = int'($urandom_range(0, 3));
      for (int g = 0; g <= d; g++) begin
        for (int l = 0; l < NL; l++) begin
          tests_run++;
          if (out_valid !== 1'b1 || result_bus[l*RW +: RW] !== narrow(exp_acc[l])) begin
            tests_failed++;
            $display("FAIL rand%0d_lane%0d: got %0d valid=%b required %0d valid=1",
                     t, l, $signed(result_bus[l*RW +: RW]), out_valid, $signed(narrow(exp_acc[l])));
          end
        end
        if (g == d) out_ready = 1'b1;
        tick();
      end
      out_ready = 1'b0;
      tests_run++;
      if (out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL rand%0d_handoff: out_valid=%b required 0", t, out_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_broadcast();
    test_saturation();
    test_gaps_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/threadgroup_array.md
THREADGROUP_ARRAY -- requirements
Module: threadgroup_array

Interface
REQ-001 SHALL have parameter NW, default 2: number of weight groups.
REQ-002 SHALL have parameter NA, default 2: number of activation groups.
REQ-003 SHALL have parameter K, default 4: elements per dot product.
REQ-004 SHALL have parameter DW, default 8: signed element width.
REQ-005 SHALL have parameter RW, default 16: signed partial-sum and result width.
REQ-006 SHALL have parameter STEPS, default 4: input beats accumulated per result, minimum 1.
REQ-007 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-008 SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-009 SHALL have port in_valid, input, 1 bit: the input beat is valid.
REQ-010 SHALL have port in_ready, output, 1 bit: the block accepts a beat.
REQ-011 SHALL have port weight_bus, input, NW*K*DW bits: group i, element k at bits [(i*K+k)*DW +: DW].
REQ-012 SHALL have port act_bus, input, NA*K*DW bits: group j, element k at bits [(j*K+k)*DW +: DW].
REQ-013 SHALL have port psum_bus, input, NW*NA*RW bits: lane i*NA+j at bits [(i*NA+j)*RW +: RW].
REQ-014 SHALL have port out_valid, output, 1 bit: result_bus holds a finished result.
REQ-015 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-016 SHALL have port result_bus, output, NW*NA*RW bits: same lane layout as psum_bus.
REQ-017 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-018 SHALL compute lane i*NA+j as the signed dot product of weight group i and activation group j; every weight group is broadcast to all NA activation groups.
REQ-019 SHALL accept a beat only on a cycle where in_valid and in_ready are both high.
REQ-020 SHALL run an FSM with three states: IDLE, ACCUM and DONE.
REQ-021 In IDLE, SHALL drive in_ready=1; an accepted beat loads acc = sign-extended psum + dot and sets cnt=1; next state is DONE if STEPS==1, else ACCUM.
REQ-022 In ACCUM, SHALL drive in_ready=1; an accepted beat does acc += dot and cnt++; the beat where cnt==STEPS-1 moves to DONE; cycles with no beat hold acc and cnt.
REQ-023 In DONE, SHALL drive in_ready=0 and out_valid=1, with result_bus held stable; out_ready=1 returns to IDLE; psum_bus is sampled only on the first beat.
REQ-024 SHALL assert out_valid on the cycle after the last beat is accepted: latency is 1 cycle from the final beat.
REQ-025 SHALL form products at 2*DW bits signed and accumulate at ACCW = 2*DW + clog2(K) + clog2(STEPS) + 1 bits, with ACCW >= RW enforced; the accumulator never wraps internally.
REQ-026 SHALL narrow acc to RW bits on output as set by REQ-032 and REQ-033.
REQ-027 SHALL ignore in_valid during DONE; if out_ready and in_valid are both high in DONE, the beat is not accepted that cycle.

Reset
REQ-028 SHALL, on a clk edge with rst==0, set state=IDLE, cnt=0, every acc=0, result_bus=0, out_valid=0 and busy=0.
REQ-029 SHALL drive in_ready=0 while rst==0, and in_ready=1 on the first cycle after release.
REQ-030 SHALL, if reset occurs during ACCUM or DONE, discard the partial result without producing any output.

Configuration
REQ-031 SHALL use macro THREADGROUP_ARRAY_SATURATE_EN to select the narrowing mode.
REQ-032 With the macro defined, SHALL clamp acc to [-2^(RW-1), 2^(RW-1)-1].
REQ-033 Without the macro, SHALL output the low RW bits of acc (two's-complement wrap).

Verification (defaults NW=NA=2, K=4, DW=8, RW=16, STEPS=4)
REQ-034 SHALL cover: all weights 1, all activations 2, all psums 10, 4 back-to-back beats -> out_valid one cycle after beat 4, all lanes 42.
REQ-035 SHALL cover: weight group0=1, group1=3; act group0=1, group1=-1; psum 0; 4 beats -> lanes {0,1,2,3} = {16,-16,48,-48}.
REQ-036 SHALL cover: weights 127, acts 127, psum 32767, 4 beats -> 32767 with the macro, 28687 without; weights -128, acts 127, psum 0 -> -32768 with the macro.
REQ-037 SHALL cover: in_valid gaps of 3 cycles between beats, then out_ready low for 5 cycles in DONE -> acc and cnt held, result stable, in_ready=0, a single handoff, then IDLE.
REQ-038 SHALL cover: rst low for 1 cycle after 2 beats -> all outputs 0; the next 4 beats (ones/2s, psum 10) give 42 on every lane with no stale contribution.
